sw_pattern_sched: RTL

//  Input scheduler for the 8-bit switch->LED datapath (module test: SW in, LED out).

---
 rtl/sw_pattern_sched_pkg.sv | 18 +
 rtl/sw_pattern_sched_btn_debounce.sv | 47 ++++
 rtl/sw_pattern_sched.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/sw_pattern_sched_pkg.sv
// Shared definitions for the switch/pattern input scheduler:
// state encodings, pattern width and the pattern advance helper.
package sw_pattern_sched_pkg;

   localparam int PAT_W = 8;

   localparam logic [1:0] S_PASS = 2'b00;
   localparam logic [1:0] S_RUN  = 2'b01;
   localparam logic [1:0] S_HOLD = 2'b10;
   localparam logic [1:0] S_DONE = 2'b11;

   // Pattern increment done in 9 bits so an overflow past LIMIT is visible
   // instead of silently wrapping.
   function automatic logic [8:0] pat_add(input logic [7:0] pat, input logic [8:0] step);
      return {1'b0, pat} + step;
   endfunction

endpackage

// File: rtl/sw_pattern_sched_btn_debounce.sv
// Level debouncer for an already-synchronised button input. The level only
// follows din after din has differed from it for DEB_CYCLES consecutive
// cycles; rise pulses for one cycle when the level goes 0->1.
module btn_debounce
   import sw_pattern_sched_pkg::*;
#(
   parameter int DEB_CYCLES = 1_000_000
) (
   input  logic CLK100MHZ,
   input  logic RST,
   input  logic din,
   output logic level,
   output logic rise
);

   localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

   logic [CNT_W-1:0] cnt_r;
   logic             level_r;
   logic             rise_r;

   // Count consecutive disagreeing cycles; accept the new level at the limit.
   always_ff @(posedge CLK100MHZ) begin
      if (RST) begin
         cnt_r   <= {CNT_W{1'b0}};
         level_r <= 1'b0;
         rise_r  <= 1'b0;
      end else if (din != level_r) begin
         if (cnt_r == CNT_MAX) begin
            cnt_r   <= {CNT_W{1'b0}};
            level_r <= din;
            rise_r  <= din;
         end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
            rise_r  <= 1'b0;
         end
      end else begin
         cnt_r  <= {CNT_W{1'b0}};
         rise_r <= 1'b0;
      end
   end

   assign level = level_r;
   assign rise  = rise_r;

endmodule

// File: rtl/sw_pattern_sched.sv
// Input scheduler for the 8-bit switch->LED datapath. Feeds the datapath
// either the live synchronised switches (PASS) or a stepping pattern
// (RUN auto-steps on a prescaler tick, HOLD single-steps on the step button).
// A pattern that would pass LIMIT stops the sweep in DONE without wrapping.
module sw_pattern_sched
   import sw_pattern_sched_pkg::*;
#(
   parameter int TICK_DIV   = 100_000_000,
   parameter int DEB_CYCLES = 1_000_000,
   parameter int STEP       = 2,
   parameter int LIMIT      = 255
) (
   input  logic             CLK100MHZ,
   input  logic             RST,
   input  logic [PAT_W-1:0] SW,
   input  logic             BTN_MODE,
   input  logic             BTN_STEP,
   output logic [PAT_W-1:0] DP_SW,
   input  logic [PAT_W-1:0] DP_LED,
   output logic [PAT_W-1:0] LED,
   output logic [1:0]       MODE,
   output logic             SWEEP_DONE
);

   localparam int PRE_W = $clog2(TICK_DIV);
   localparam logic [PRE_W-1:0] TICK_MAX = PRE_W'(TICK_DIV - 1);
   localparam logic [8:0]       STEP_B   = 9'(STEP);
   localparam logic [8:0]       LIMIT_B  = 9'(LIMIT);

   logic [PAT_W-1:0] sw_m_r, sw_s_r;
   logic [1:0]       btn_m_r, btn_s_r;     // {step, mode}
   logic             mode_lvl_s, step_lvl_s, mode_p_s, step_p_s;
   logic             btn_lvl_unused_s;
   logic [1:0]       state_r, state_nxt_s;
   logic [PAT_W-1:0] pattern_r, pattern_nxt_s;
   logic [PRE_W-1:0] presc_r;
   logic             tick_s;
   logic [8:0]       adv_s;
   logic             adv_ovf_s;
   logic [PAT_W-1:0] dp_sw_r, led_r;
   logic             sweep_done_r;

   // Two-flop synchronisers for the switches and both buttons.
   always_ff @(posedge CLK100MHZ) begin
      if (RST) begin
         sw_m_r  <= {PAT_W{1'b0}};
         sw_s_r  <= {PAT_W{1'b0}};
         btn_m_r <= 2'b00;
         btn_s_r <= 2'b00;
      end else begin
         sw_m_r  <= SW;
         sw_s_r  <= sw_m_r;
         btn_m_r <= {BTN_STEP, BTN_MODE};
         btn_s_r <= btn_m_r;
      end
   end

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
      .CLK100MHZ (CLK100MHZ),
      .RST       (RST),
      .din       (btn_s_r[0]),
      .level     (mode_lvl_s),
      .rise      (mode_p_s)
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
      .CLK100MHZ (CLK100MHZ),
      .RST       (RST),
      .din       (btn_s_r[1]),
      .level     (step_lvl_s),
      .rise      (step_p_s)
   );

   // Only the edge pulses drive the scheduler; debounced levels are spare.
   assign btn_lvl_unused_s = mode_lvl_s ^ step_lvl_s;

   assign tick_s = (state_r == S_RUN) && (presc_r == TICK_MAX);

   // Prescaler runs only in RUN, so the first tick lands TICK_DIV cycles after entry.
   always_ff @(posedge CLK100MHZ) begin
      if (RST) begin
         presc_r <= {PRE_W{1'b0}};
      end else if ((state_r != S_RUN) || tick_s) begin
         presc_r <= {PRE_W{1'b0}};
      end else begin
         presc_r <= presc_r + PRE_W'(1);
      end
   end

   // Next state / pattern; mode button outranks step button and tick.
   always_comb begin
      state_nxt_s   = state_r;
      pattern_nxt_s = pattern_r;
      adv_s         = pat_add(pattern_r, STEP_B);
      adv_ovf_s     = (adv_s > LIMIT_B);
      case (state_r)
         S_PASS: begin
            if (mode_p_s) begin
               state_nxt_s   = S_RUN;
               pattern_nxt_s = sw_s_r;
            end else begin
               state_nxt_s   = S_PASS;
            end
         end
         S_RUN: begin
            if (mode_p_s) begin
               state_nxt_s = S_HOLD;
            end else if (tick_s && adv_ovf_s) begin
               state_nxt_s = S_DONE;
            end else if (tick_s) begin
               pattern_nxt_s = adv_s[PAT_W-1:0];
            end else begin
               state_nxt_s = S_RUN;
            end
         end
         S_HOLD: begin
            if (mode_p_s) begin
               state_nxt_s = S_PASS;
            end else if (step_p_s && adv_ovf_s) begin
               state_nxt_s = S_DONE;
            end else if (step_p_s) begin
               pattern_nxt_s = adv_s[PAT_W-1:0];
            end else begin
               state_nxt_s = S_HOLD;
            end
         end
         S_DONE: begin
            if (mode_p_s) begin
               state_nxt_s = S_PASS;
            end else if (step_p_s) begin
               state_nxt_s   = S_RUN;
               pattern_nxt_s = {PAT_W{1'b0}};
            end else begin
               state_nxt_s = S_DONE;
            end
         end
         default: begin
            state_nxt_s   = S_PASS;
            pattern_nxt_s = {PAT_W{1'b0}};
         end
      endcase
   end

   // State, pattern and all board/datapath-facing output registers.
   always_ff @(posedge CLK100MHZ) begin
      if (RST) begin
         state_r      <= S_PASS;
         pattern_r    <= {PAT_W{1'b0}};
         dp_sw_r      <= {PAT_W{1'b0}};
         led_r        <= {PAT_W{1'b0}};
         sweep_done_r <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         pattern_r    <= pattern_nxt_s;
         dp_sw_r      <= (state_r == S_PASS) ? sw_s_r : pattern_r;
         led_r        <= DP_LED;
         sweep_done_r <= (state_nxt_s == S_DONE);
      end
   end

   assign DP_SW      = dp_sw_r;
   assign LED        = led_r;
   assign MODE       = state_r;
   assign SWEEP_DONE = sweep_done_r;

endmodule
